// File: rtl/requant_shift_arbiter.sv
// requant_shift_arbiter
//   Shares one rounding divide-by-power-of-two datapath among NUM_REQ requesters
//   in the requantisation stage. Requests are picked round-robin. Each one passes
//   through an operand register (S1), the combinational divider, and a result
//   register (S2). Its response is then returned only to the requester that issued it.
//
// Ports
//   clk           single clock, all state on the rising edge
//   rst           synchronous, active-high reset
//   req_valid     per-requester request valid
//   req_ready     per-requester accept (one-hot or zero)
//   req_dividend  32-bit dividend per requester, requester i at [32*i +: 32]
//   req_exponent  6-bit shift per requester, requester i at [6*i +: 6]
//   rsp_valid     per-requester response valid (one-hot or zero)
//   rsp_ready     per-requester response accept
//   rsp_quotient  shared result bus for the requester whose rsp_valid is high
//   rsp_err       result came from an exponent above 31 that was clamped
//   busy          either pipeline stage is occupied

`timescale 1ns/1ps

// Unsigned divide by 2^exponent with round-half-up. The bit just below the
// cut is the rounding increment. The sum cannot overflow for exponent >= 1,
// because the shifted value is then below 2^31.
module divider_by_powerof2 (
    input  logic [31:0] dividend,
    input  logic [4:0]  exponent,
    output logic [31:0] quotient
);
    logic round_bit;

    always_comb begin
        round_bit = 1'b0;
        if (exponent != 5'd0) begin
            round_bit = dividend[exponent - 5'd1];
        end
        quotient = (dividend >> exponent) + {31'd0, round_bit};
    end
endmodule

module requant_shift_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [32*NUM_REQ-1:0]  req_dividend,
    input  logic [6*NUM_REQ-1:0]   req_exponent,
    output logic [NUM_REQ-1:0]     rsp_valid,
    input  logic [NUM_REQ-1:0]     rsp_ready,
    output logic [31:0]            rsp_quotient,
    output logic                   rsp_err,
    output logic                   busy
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic            v1, v2;
    logic [ID_W-1:0] id1, id2;
    logic [31:0]     dividend1;
    logic [4:0]      exp1;
    logic            err1;
    logic [31:0]     quotient2;
    logic            err2;
    logic [ID_W-1:0] rr;

    logic            s1_adv, s2_adv;
    logic            grant_found;
    logic [ID_W-1:0] grant_id;
    logic            req_fire;
    logic [31:0]     sel_dividend;
    logic [5:0]      sel_exponent;
    logic [31:0]     div_quotient;

    // S2 empties when its holder accepts. S1 can move whenever S2 can take it.
    assign s2_adv   = ~v2 | rsp_ready[id2];
    assign s1_adv   = ~v1 | s2_adv;
    assign req_fire = grant_found & s1_adv;
    assign busy     = v1 | v2;

    // Round-robin search that starts at rr and wraps at NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && req_valid[(int'(rr) + k) % NUM_REQ]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'((int'(rr) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (req_fire) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign sel_dividend = req_dividend[32*int'(grant_id) +: 32];
    assign sel_exponent = req_exponent[6*int'(grant_id) +: 6];

    divider_by_powerof2 u_div (
        .dividend (dividend1),
        .exponent (exp1),
        .quotient (div_quotient)
    );

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = v2 && (id2 == ID_W'(i));
        end
    end

    assign rsp_quotient = quotient2;
    assign rsp_err      = err2;

    // Pipeline registers and the round-robin pointer. The S2 payload only
    // changes when a valid entry moves in. This keeps the response bus steady
    // while a requester stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            id1       <= '0;
            id2       <= '0;
            dividend1 <= '0;
            exp1      <= '0;
            err1      <= 1'b0;
            quotient2 <= '0;
            err2      <= 1'b0;
            rr        <= '0;
        end else begin
            if (s2_adv) begin
                v2 <= v1;
                if (v1) begin
                    id2       <= id1;
                    quotient2 <= div_quotient;
                    err2      <= err1;
                end
            end
            if (s1_adv) begin
                v1 <= req_fire;
                if (req_fire) begin
                    id1       <= grant_id;
                    dividend1 <= sel_dividend;
                    exp1      <= sel_exponent[5] ? 5'd31 : sel_exponent[4:0];
                    err1      <= sel_exponent[5];
                    if (int'(grant_id) == NUM_REQ - 1) begin
                        rr <= '0;
                    end else begin
                        rr <= grant_id + ID_W'(1);
                    end
                end
            end
        end
    end
endmodule
